// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture
//   Receive-side monitor for one servo PWM line. The module measures the high
//   time and the rise-to-rise period of the line in clk cycles. It flags
//   published widths outside the legal servo window and reports loss of signal.
//
// Ports
//   clk           system clock (pll_clk domain)
//   rst_n         asynchronous active-low reset
//   pwm_in        servo PWM line, asynchronous to clk
//   clr           synchronous clear of out_of_range and no_signal
//   pulse_width   last complete high time, clk cycles
//   period        last complete rise-to-rise period, clk cycles
//   valid         one-cycle strobe: pulse_width/period just updated
//   out_of_range  sticky: a published width was < MIN_PULSE or > MAX_PULSE
//   no_signal     level: no synchronized edge for TIMEOUT cycles
module servo_pwm_capture #(
  parameter int CNT_W     = 32,
  parameter int MIN_PULSE = 100000,
  parameter int MAX_PULSE = 200000,
  parameter int TIMEOUT   = 4000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             out_of_range,
  output logic             no_signal
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Saturating increment: measurement counters never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------
  logic       s1_reg, s2_reg, s3_reg;
  // fill_reg[2] is set once s3_reg holds a genuine sample of pwm_in. Until
  // then, s3_reg is only its reset value. Gating edges on this flag prevents a
  // line that is already high at reset from producing a false rise.
  logic [2:0] fill_reg;
  logic       rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      fill_reg <= 3'b000;
    end else begin
      s1_reg   <= pwm_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      fill_reg <= {fill_reg[1:0], 1'b1};
    end
  end

  assign rise = fill_reg[2] &  s2_reg & ~s3_reg;
  assign fall = fill_reg[2] & ~s2_reg &  s3_reg;

  // ---------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] period_cnt_reg;
  logic [CNT_W-1:0] high_cnt_reg;
  logic [CNT_W-1:0] width_reg;
  logic [CNT_W-1:0] idle_cnt_reg;

  logic [CNT_W-1:0] idle_next;
  logic [CNT_W-1:0] period_inc;
  logic [CNT_W-1:0] high_inc;
  logic             timeout_hit;
  logic             publish;
  logic             width_bad;

  always_comb begin
    idle_next  = (rise | fall) ? '0 : sat_inc(idle_cnt_reg);
    period_inc = sat_inc(period_cnt_reg);
    high_inc   = sat_inc(high_cnt_reg);
    // The idle counter saturates above TIMEOUT, so this equality fires only
    // once per silent stretch.
    timeout_hit = (idle_next == TIMEOUT_C);
    publish     = (state_reg == ST_LOW) && rise;
    // The range check applies to the width being published in this cycle.
    width_bad   = (width_reg < MIN_C) || (width_reg > MAX_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
      width_reg      <= '0;
      idle_cnt_reg   <= '0;
      pulse_width    <= '0;
      period         <= '0;
      valid          <= 1'b0;
    end else begin
      idle_cnt_reg <= idle_next;
      valid        <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // A fall seen here is ignored, so capture always starts on a rise.
          if (rise) begin
            period_cnt_reg <= CNT_ONE;
            high_cnt_reg   <= CNT_ONE;
            state_reg      <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (timeout_hit) begin
            state_reg <= ST_IDLE;
          end else if (fall) begin
            // The fall cycle still counts toward the period. high_cnt_reg
            // already equals the number of high samples.
            width_reg      <= high_cnt_reg;
            period_cnt_reg <= period_inc;
            state_reg      <= ST_LOW;
          end else begin
            period_cnt_reg <= period_inc;
            high_cnt_reg   <= high_inc;
          end
        end

        ST_LOW: begin
          if (timeout_hit) begin
            state_reg <= ST_IDLE;
          end else if (rise) begin
            pulse_width    <= width_reg;
            period         <= period_cnt_reg;
            valid          <= 1'b1;
            period_cnt_reg <= CNT_ONE;
            high_cnt_reg   <= CNT_ONE;
            state_reg      <= ST_HIGH;
          end else begin
            period_cnt_reg <= period_inc;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_range <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      // A new violation takes priority over a simultaneous clear.
      if (publish && width_bad) begin
        out_of_range <= 1'b1;
      end else if (clr) begin
        out_of_range <= 1'b0;
      end

      // rise and timeout_hit cannot coincide, because an edge zeroes idle_next.
      if (rise) begin
        no_signal <= 1'b0;
      end else if (timeout_hit) begin
        no_signal <= 1'b1;
      end else if (clr) begin
        no_signal <= 1'b0;
      end
    end
  end

endmodule
